// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN grid result reader: grid geometry, cell word type, FSM states.
package cnn_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CELLS = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned VEC_W = CELLS * (WIDTH + 1);

    typedef logic signed [WIDTH:0] cell_t;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StCapture,
        StStream
    } reader_state_e;

endpackage

// File: rtl/cnn_vec_compare.sv
// Registered all-cells comparison of two grid vectors.
// With CNN_READER_TOL_EN defined, cells match when |a-b| <= tol; otherwise exact equality.
module cnn_vec_compare
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [VEC_W-1:0] vec_a,
    input  logic [VEC_W-1:0] vec_b,
`ifdef CNN_READER_TOL_EN
    input  logic [WIDTH-1:0] tol,
`endif
    output logic             all_eq
);

    logic match;

`ifdef CNN_READER_TOL_EN
    logic signed [WIDTH+1:0] ext_a;
    logic signed [WIDTH+1:0] ext_b;
    logic signed [WIDTH+1:0] diff;
    logic        [WIDTH+1:0] mag;

    // One extra bit beyond the sign extension keeps the difference from overflowing.
    always_comb begin
        match = 1'b1;
        ext_a = '0;
        ext_b = '0;
        diff  = '0;
        mag   = '0;
        for (int k = 0; k < CELLS; k++) begin
            ext_a = {vec_a[k*(WIDTH+1)+WIDTH], vec_a[k*(WIDTH+1) +: WIDTH+1]};
            ext_b = {vec_b[k*(WIDTH+1)+WIDTH], vec_b[k*(WIDTH+1) +: WIDTH+1]};
            diff  = ext_a - ext_b;
            mag   = diff[WIDTH+1] ? -diff : diff;
            if (mag > {2'b00, tol}) begin
                match = 1'b0;
            end
        end
    end
`else
    always_comb begin
        match = 1'b1;
        for (int k = 0; k < CELLS; k++) begin
            if (vec_a[k*(WIDTH+1) +: WIDTH+1] != vec_b[k*(WIDTH+1) +: WIDTH+1]) begin
                match = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            all_eq <= 1'b0;
        end else begin
            all_eq <= match;
        end
    end

endmodule

// File: rtl/cnn_grid_result_reader.sv
// Captures grid sweeps, detects convergence (or sweep limit) and streams the 16 final cells.
// Optional CNN_READER_TOL_EN adds a tolerance input for the convergence compare.
module cnn_grid_result_reader
    import cnn_pkg::*;
#(
    parameter int unsigned MAX_SWEEPS  = 64,
    parameter int unsigned SWEEP_CNT_W = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sweep_tick,
    input  logic [VEC_W-1:0]       y_in,
`ifdef CNN_READER_TOL_EN
    input  logic [WIDTH-1:0]       tol,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH:0]         out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   converged,
    output logic [SWEEP_CNT_W-1:0] sweeps
);

    localparam logic [SWEEP_CNT_W-1:0] MAX_CNT  = SWEEP_CNT_W'(MAX_SWEEPS);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(CELLS - 1);

    reader_state_e          state_q, state_d;
    logic [VEC_W-1:0]       prev_q, prev_d;
    logic [VEC_W-1:0]       cur_q, cur_d;
    logic [SWEEP_CNT_W-1:0] sweeps_q, sweeps_d;
    logic                   conv_q, conv_d;
    logic                   prev_valid_q, prev_valid_d;
    logic                   decide_q, decide_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   cells_eq;
    cell_t                  out_word;

    // Compares the incoming sweep against prev at the tick, so the result is ready
    // in the decision cycle that follows and matches cur vs prev.
    cnn_vec_compare u_compare (
        .clk    (clk),
        .rst    (rst),
        .vec_a  (y_in),
        .vec_b  (prev_q),
`ifdef CNN_READER_TOL_EN
        .tol    (tol),
`endif
        .all_eq (cells_eq)
    );

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        cur_d        = cur_q;
        sweeps_d     = sweeps_q;
        conv_d       = conv_q;
        prev_valid_d = prev_valid_q;
        decide_d     = 1'b0;
        idx_d        = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StArm;
                    sweeps_d     = '0;
                    conv_d       = 1'b0;
                    prev_valid_d = 1'b0;
                end
            end
            StArm: begin
                if (sweep_tick) begin
                    prev_d       = y_in;
                    prev_valid_d = 1'b1;
                    sweeps_d     = SWEEP_CNT_W'(1);
                    state_d      = StCapture;
                end
            end
            StCapture: begin
                if (decide_q) begin
                    if (cells_eq) begin
                        conv_d  = 1'b1;
                        idx_d   = '0;
                        state_d = StStream;
                    end else if (sweeps_q >= MAX_CNT) begin
                        conv_d  = 1'b0;
                        idx_d   = '0;
                        state_d = StStream;
                    end else begin
                        prev_d = cur_q;
                    end
                end else if (sweep_tick && prev_valid_q) begin
                    cur_d    = y_in;
                    decide_d = 1'b1;
                    if (sweeps_q < MAX_CNT) begin
                        sweeps_d = sweeps_q + SWEEP_CNT_W'(1);
                    end
                end
            end
            StStream: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            prev_q       <= '0;
            cur_q        <= '0;
            sweeps_q     <= '0;
            conv_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            decide_q     <= 1'b0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cur_q        <= cur_d;
            sweeps_q     <= sweeps_d;
            conv_q       <= conv_d;
            prev_valid_q <= prev_valid_d;
            decide_q     <= decide_d;
            idx_q        <= idx_d;
        end
    end

    always_comb begin
        out_word = '0;
        for (int k = 0; k < CELLS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                out_word = cur_q[k*(WIDTH+1) +: WIDTH+1];
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StStream);
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign out_data  = out_valid ? out_word : '0;
    assign converged = conv_q;
    assign sweeps    = sweeps_q;

endmodule

// File: tb/tb_cnn_grid_result_reader.sv
// Randomized self-checking bench for cnn_grid_result_reader against a sweep-level reference model.
module tb_cnn_grid_result_reader;
    import cnn_pkg::*;

    localparam int MAXS = 4;
    localparam int CW   = WIDTH + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              sweep_tick;
    logic [VEC_W-1:0]  y_in;
    logic              out_valid;
    logic              out_ready;
    logic signed [8:0] out_data;
    logic [3:0]        out_idx;
    logic              out_last;
    logic              busy;
    logic              converged;
    logic [6:0]        sweeps;
`ifdef CNN_READER_TOL_EN
    logic [7:0]        tol;
`endif

    int total = 0;
    int bad   = 0;
    int tol_m = 0;
    logic [VEC_W-1:0] seq [MAXS];

    cnn_grid_result_reader #(
        .MAX_SWEEPS  (MAXS),
        .SWEEP_CNT_W (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sweep_tick (sweep_tick),
        .y_in       (y_in),
`ifdef CNN_READER_TOL_EN
        .tol        (tol),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy),
        .converged  (converged),
        .sweeps     (sweeps)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int cell_of(input logic [VEC_W-1:0] v, input int k);
        logic signed [CW-1:0] c;
        c = v[k*CW +: CW];
        return int'(c);
    endfunction

    function automatic logic [VEC_W-1:0] make_vec(input int val);
        logic [VEC_W-1:0] v;
        for (int k = 0; k < CELLS; k++) v[k*CW +: CW] = 9'(val);
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int k = 0; k < CELLS; k++) v[k*CW +: CW] = 9'($urandom_range(0, 511));
        return v;
    endfunction

    // Two sweeps agree when every cell differs by at most the tolerance.
    function automatic bit vec_match(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                                     input int t);
        int d;
        for (int k = 0; k < CELLS; k++) begin
            d = cell_of(a, k) - cell_of(b, k);
            if (d < 0) d = -d;
            if (d > t) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic gen_seq();
        logic [VEC_W-1:0] v;
        int k;
        seq[0] = rand_vec();
        for (int i = 1; i < MAXS; i++) begin
            v = seq[i-1];
            case ($urandom_range(0, 3))
                0: ;
                1: begin
                    k = $urandom_range(0, CELLS - 1);
                    v[k*CW +: CW] = v[k*CW +: CW] + 9'($urandom_range(1, 3));
                end
                default: v = rand_vec();
            endcase
            seq[i] = v;
        end
    endtask

    task automatic run_case(input int ready_mode, input int abort_after, input bit noise);
        logic [VEC_W-1:0] prev_v, final_v;
        int  m_n, used, xfers, cyc;
        bit  m_conv, rdy;
        // Reference: first sweep arms, each later sweep either matches the previous one,
        // hits the sweep limit, or becomes the new previous.
        prev_v = seq[0]; final_v = seq[0]; m_n = 1; used = 1; m_conv = 1'b0;
        for (int i = 1; i < MAXS; i++) begin
            m_n++; used++; final_v = seq[i];
            if (vec_match(seq[i], prev_v, tol_m)) begin
                m_conv = 1'b1;
                break;
            end
            if (m_n == MAXS) break;
            prev_v = seq[i];
        end
`ifdef CNN_READER_TOL_EN
        tol = 8'(tol_m);
`endif
        @(negedge clk);
        start = 1'b1;
        if (noise) begin
            sweep_tick = 1'b1;
            y_in = rand_vec();
        end
        @(negedge clk);
        start = 1'b0; sweep_tick = 1'b0;
        check_eq("arm_busy", int'(busy), 1);
        check_eq("arm_valid", int'(out_valid), 0);
        check_eq("arm_sweeps", int'(sweeps), 0);
        check_eq("arm_conv", int'(converged), 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);

        for (int t = 0; t < used; t++) begin
            y_in = seq[t]; sweep_tick = 1'b1;
            @(negedge clk);
            sweep_tick = 1'b0; y_in = rand_vec();
            if (t > 0 && noise) begin
                sweep_tick = 1'b1;
                start = 1'b1;
            end
            if (t == used - 1) begin
                check_eq("decide_valid", int'(out_valid), 0);
                check_eq("decide_busy", int'(busy), 1);
            end
            @(negedge clk);
            sweep_tick = 1'b0; start = 1'b0;
            if (t < used - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        xfers = 0; cyc = 0;
        while (xfers < CELLS && cyc < 200) begin
            check_eq("s_valid", int'(out_valid), 1);
            check_eq("s_idx", int'(out_idx), xfers);
            check_eq("s_data", int'(out_data), cell_of(final_v, xfers));
            check_eq("s_last", int'(out_last), int'(xfers == CELLS - 1));
            if (abort_after == xfers) begin
                rst = 1'b1; out_ready = 1'b0;
                @(negedge clk);
                check_eq("rst_valid", int'(out_valid), 0);
                check_eq("rst_busy", int'(busy), 0);
                check_eq("rst_conv", int'(converged), 0);
                check_eq("rst_sweeps", int'(sweeps), 0);
                check_eq("rst_idx", int'(out_idx), 0);
                check_eq("rst_data", int'(out_data), 0);
                check_eq("rst_last", int'(out_last), 0);
                rst = 1'b0;
                return;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc % 3 == 0);
            endcase
            out_ready = rdy;
            if (noise && $urandom_range(0, 3) == 0) begin
                sweep_tick = 1'b1;
                start = 1'b1;
                y_in = rand_vec();
            end
            @(negedge clk);
            sweep_tick = 1'b0; start = 1'b0;
            cyc++;
            if (rdy) xfers++;
        end
        out_ready = 1'b0;
        check_eq("stream_len", xfers, CELLS);
        if (ready_mode == 0) check_eq("stream_cycles", cyc, CELLS);
        check_eq("end_valid", int'(out_valid), 0);
        check_eq("end_busy", int'(busy), 0);
        check_eq("end_conv", int'(converged), int'(m_conv));
        check_eq("end_sweeps", int'(sweeps), m_n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; sweep_tick = 1'b0; out_ready = 1'b0; y_in = '0;
`ifdef CNN_READER_TOL_EN
        tol = '0;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset_valid", int'(out_valid), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_conv", int'(converged), 0);
        check_eq("reset_sweeps", int'(sweeps), 0);
        check_eq("reset_data", int'(out_data), 0);
        rst = 1'b0;

        // Converges on the second sweep of all fives.
        seq[0] = make_vec(5); seq[1] = make_vec(5); seq[2] = rand_vec(); seq[3] = rand_vec();
        run_case(0, -1, 1'b0);

        // Cell 3 alternates 1/-1 so the sweep limit stops the run.
        for (int i = 0; i < MAXS; i++) begin
            seq[i] = make_vec(0);
            seq[i][3*CW +: CW] = (i % 2 == 0) ? 9'sd1 : -9'sd1;
        end
        run_case(0, -1, 1'b0);

        // Backpressure with ready pattern 1,0,0,...
        seq[0] = rand_vec(); seq[1] = seq[0]; seq[2] = rand_vec(); seq[3] = rand_vec();
        run_case(2, -1, 1'b0);

        // Reset after 7 transfers, then a normal run.
        gen_seq();
        run_case(1, 7, 1'b0);
        seq[0] = rand_vec(); seq[1] = rand_vec(); seq[2] = seq[1]; seq[3] = rand_vec();
        run_case(0, -1, 1'b0);

        // Starts and ticks where they must be ignored.
        seq[0] = rand_vec(); seq[1] = rand_vec(); seq[2] = seq[1]; seq[3] = rand_vec();
        run_case(1, -1, 1'b1);

        for (int n = 0; n < 20; n++) begin
            gen_seq();
`ifdef CNN_READER_TOL_EN
            tol_m = $urandom_range(0, 3);
`endif
            run_case($urandom_range(0, 2), -1, 1'($urandom_range(0, 1)));
        end

`ifdef CNN_READER_TOL_EN
        for (int i = 0; i < MAXS; i++) begin
            seq[i] = make_vec(0);
            seq[i][0 +: CW] = 9'(-256 + 2 * i);
        end
        tol_m = 2;
        run_case(0, -1, 1'b0);
        tol_m = 1;
        run_case(0, -1, 1'b0);
        tol_m = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnn_grid_result_reader.md
Name: cnn_grid_result_reader

Overview:
Output-side companion to the 4x4 time-multiplexed CNN grid engine. The engine presents all 16 cell states in parallel and refreshes them once per 16-cycle sweep. This block captures the state vector at each sweep boundary and detects convergence, meaning two consecutive sweeps are identical. It then streams the 16 final cell values out serially over a valid/ready interface, together with run status.

Parameters:
WIDTH, 8, magnitude width; every cell word is signed WIDTH+1 bits (matches the grid engine's data format)
CELLS, 16, cells per grid (4x4); stream index width is clog2(CELLS)
MAX_SWEEPS, 64, sweep limit before a forced stop when convergence has not been reached
SWEEP_CNT_W, 7, width of the sweep counter and of the sweeps output

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a run; ignored unless in IDLE
sweep_tick  in  1  pulse marking that y_in holds a complete, freshly updated sweep
y_in  in  CELLS*(WIDTH+1)  parallel cell states; cell k occupies bits [k*(WIDTH+1) +: WIDTH+1], cell 0 = Y1
out_valid  out  1  stream word valid
out_ready  in  1  downstream accept
out_data  out  WIDTH+1  signed cell value
out_idx  out  4  cell index 0..15 of out_data
out_last  out  1  high with out_idx==CELLS-1
busy  out  1  high in every state except IDLE
converged  out  1  1 = stopped on convergence, 0 = stopped on the sweep limit; holds until next start
sweeps  out  SWEEP_CNT_W  number of sweeps captured in the last run; holds until next start

Behaviour:
- Reset clears all state and forces every output to 0; FSM goes to IDLE. Reset applies in any state and aborts a run immediately.
- FSM states: IDLE, ARM, CAPTURE, STREAM.
- IDLE:
  - start=1 -> ARM; clear sweeps, converged and the prev_valid flag.
- ARM:
  - Wait for the first sweep_tick; latch y_in into prev, set prev_valid, sweeps=1, go to CAPTURE.
- CAPTURE:
  - On each sweep_tick, latch y_in into cur and increment sweeps.
  - If cur equals prev on all 16 cells: converged=1, go to STREAM.
  - Else, if sweeps has reached MAX_SWEEPS: converged=0, go to STREAM.
  - Otherwise prev<=cur and keep waiting.
  - The equality check is registered: the decision is made one cycle after the tick. Any sweep_tick arriving during that decision cycle is ignored.
- STREAM:
  - Source register is cur, frozen for the whole stream.
  - out_valid=1 from the first STREAM cycle, starting at out_idx=0.
  - A word transfers when out_valid&&out_ready; idx then increments.
  - out_data, out_idx and out_last are stable while out_valid=1 and out_ready=0.
  - The transfer at idx 15 returns the FSM to IDLE; out_valid drops the next cycle.
  - sweep_tick is ignored in STREAM.
- start is ignored in every state except IDLE; it is never queued.
- Latency: first word is valid 2 cycles after the converging sweep_tick. Full stream is 16 cycles when out_ready is held high.
- Widths: comparisons are on the full WIDTH+1 bits, signed. sweeps saturates at MAX_SWEEPS and never wraps.
- Simultaneous start and sweep_tick in IDLE: only start is acted on; that tick does not count as the ARM capture.

Optional Feature:
- Macro: CNN_READER_TOL_EN.
- Defined: adds input port tol (WIDTH bits, unsigned). A cell counts as equal when |cur-prev| <= tol. The difference is computed in WIDTH+2 bits so it cannot overflow.
- Not defined: exact bitwise equality; tol port absent.

Decomposition:
- Shared package cnn_pkg holds: WIDTH, CELLS and the cell word typedef (signed WIDTH+1 bits). Reader FSM state enum. Helper constant IDX_W = 4.
- One natural sub-module: cnn_vec_compare. Combinational all-cells equal/tolerance check over two CELLS-wide vectors, registered output; isolates the optional tolerance logic.

Test Plan:
- Convergence: start; tick with all cells=5; tick with all cells=5 -> converged=1, sweeps=2, stream 16 words of 5, idx 0..15, out_last on idx 15.
- Sweep limit, MAX_SWEEPS=4: each tick alternates cell 3 between 1 and -1 -> stop after 4 ticks, converged=0, sweeps=4, word idx3 = -1.
- Backpressure: out_ready toggled 1,0,0,1,... -> no word dropped or duplicated, out_data stable while stalled, 16 transfers total.
- Reset mid-STREAM after 7 transfers -> next cycle out_valid=0, busy=0, converged=0, sweeps=0; a new start runs normally.
- Ignored events: start during CAPTURE and a sweep_tick during STREAM -> no state change, sweeps unchanged.
- With CNN_READER_TOL_EN, tol=2: ticks with cell0 = -256 then -254 -> converged=1, sweeps=2. With tol=1 on the same stimulus -> not converged.
